// File: rtl/bvb_sched_pkg.sv
// Shared definitions for the bank-vector-buffer read scheduler.
package bvb_sched_pkg;

    // Default geometry of the vector RAM and its image layout
    localparam int DEF_RAM_SPLIT_BITS = 2;
    localparam int DEF_RAM_SPLITS     = 4;
    localparam int DEF_BVB_ADDR_SIZE  = 7;
    localparam int DEF_IMAGE_STRIDE   = 4;

    // Scheduler states: pick a bank, let its data land, or move to the next image
    typedef enum logic [1:0] {
        ST_SELECT  = 2'd0,
        ST_READ    = 2'd1,
        ST_ADVANCE = 2'd2
    } state_t;

endpackage

// File: rtl/bvb_sched_if.sv
// Bundle of FIFO-side and RAM-side signals around the scheduler.
interface bvb_sched_if
    import bvb_sched_pkg::*;
#(
    parameter int channel_num    = 4,
    parameter int col_id_size    = 10,
    parameter int ram_split_bits = DEF_RAM_SPLIT_BITS,
    parameter int bvb_addr_size  = DEF_BVB_ADDR_SIZE
);
    logic [channel_num*col_id_size-1:0] id;
    logic [channel_num-1:0]             id_fifo_empty;
    logic [channel_num-1:0]             vec_fifo_full;
    logic                               img_next;
    logic                               ram_en;
    logic [bvb_addr_size:0]             ram_addr;
    logic [channel_num-1:0]             id_fifo_read;
    logic [channel_num-1:0]             vec_fifo_wr_en;
    logic [ram_split_bits-1:0]          cur_bank;
    logic                               img_done;

    modport master (
        output id, id_fifo_empty, vec_fifo_full, img_next,
        input  ram_en, ram_addr, id_fifo_read, vec_fifo_wr_en, cur_bank, img_done
    );

    modport slave (
        input  id, id_fifo_empty, vec_fifo_full, img_next,
        output ram_en, ram_addr, id_fifo_read, vec_fifo_wr_en, cur_bank, img_done
    );
endinterface

// File: rtl/bvb_sched_rr_pick.sv
// Round-robin first-one finder: nearest set mask bit at or after start, with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] idx,
    output logic          valid
);
    // Scan offsets from farthest to nearest so the nearest hit is written last
    always_comb begin
        int j;
        j     = 0;
        idx   = '0;
        valid = |mask;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(start) + i) % N;
            if (mask[j]) begin
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/bvb_sched.sv
// Schedules banked vector-RAM reads for several id/vec channel pairs, one bank
// every two cycles, and steps the RAM window from image to image on request.
module bvb_sched
    import bvb_sched_pkg::*;
#(
    parameter int channel_num    = 4,
    parameter int col_id_size    = 10,
    parameter int ram_split_bits = DEF_RAM_SPLIT_BITS,
    parameter int ram_splits     = DEF_RAM_SPLITS,
    parameter int bvb_addr_size  = DEF_BVB_ADDR_SIZE,
    parameter int image_stride   = DEF_IMAGE_STRIDE
) (
    input logic        clk,
    input logic        rst,
    bvb_sched_if.slave bus
);
    localparam int AW = bvb_addr_size + 1;

    state_t                            state_q, state_d;
    logic [AW-1:0]                     image_start_q, image_start_d;
    logic [ram_split_bits-1:0]         cur_bank_q, cur_bank_d;
    logic                              next_flag_q, next_flag_d;
    logic                              ram_en_q, ram_en_d;
    logic [AW-1:0]                     ram_addr_q, ram_addr_d;
    logic [channel_num-1:0]            grant_q, grant_d;
    logic                              img_done_q, img_done_d;

    logic [channel_num-1:0]                     eligible;
    logic [channel_num-1:0][ram_split_bits-1:0] ch_bank;
    logic [ram_splits-1:0]                      pending;
    logic [ram_split_bits-1:0]                  rr_start;
    logic [ram_split_bits-1:0]                  pick_idx;
    logic                                       pick_vld;
    logic                                       unused_id_bits;

    // Only the bank field of each id matters here; the rest goes to the RAM side
    assign unused_id_bits = ^bus.id;

    // Decode each head id into its bank and collect the banks someone is waiting on
    always_comb begin
        pending  = '0;
        eligible = '0;
        ch_bank  = '0;
        for (int c = 0; c < channel_num; c++) begin
            eligible[c] = ~bus.id_fifo_empty[c] & ~bus.vec_fifo_full[c];
            ch_bank[c]  = bus.id[c*col_id_size + col_id_size - 1 -: ram_split_bits];
            if (eligible[c] && (int'(ch_bank[c]) < ram_splits)) begin
                pending[ch_bank[c]] = 1'b1;
            end
        end
    end

    // Search begins one past the last bank served so every bank gets its turn
    always_comb begin
        rr_start = (int'(cur_bank_q) == ram_splits - 1) ? '0 : cur_bank_q + 1'b1;
    end

    rr_pick #(
        .N  (ram_splits),
        .IW (ram_split_bits)
    ) u_rr_pick (
        .mask  (pending),
        .start (rr_start),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Next-state and registered-output logic of the scheduler FSM
    always_comb begin
        state_d       = state_q;
        image_start_d = image_start_q;
        cur_bank_d    = cur_bank_q;
        next_flag_d   = next_flag_q | bus.img_next;
        ram_en_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        grant_d       = '0;
        img_done_d    = 1'b0;
        unique case (state_q)
            ST_SELECT: begin
                // An image change waits until every id FIFO has drained
                if (next_flag_q && (&bus.id_fifo_empty)) begin
                    state_d = ST_ADVANCE;
                end else if (pick_vld) begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = image_start_q + AW'(pick_idx);
                    cur_bank_d = pick_idx;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                // RAM data for cur_bank is valid alongside these strobes
                for (int c = 0; c < channel_num; c++) begin
                    grant_d[c] = eligible[c] && (ch_bank[c] == cur_bank_q);
                end
                state_d = ST_SELECT;
            end
            ST_ADVANCE: begin
                image_start_d = image_start_q + AW'(image_stride);
                img_done_d    = 1'b1;
                cur_bank_d    = '0;
                // A request arriving right now belongs to the following image
                next_flag_d   = bus.img_next;
                state_d       = ST_SELECT;
            end
            default: begin
                state_d = ST_SELECT;
            end
        endcase
    end

    // State and output registers; reset also kills any grant due this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SELECT;
            image_start_q <= '0;
            cur_bank_q    <= ram_split_bits'(ram_splits - 1);
            next_flag_q   <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_addr_q    <= '0;
            grant_q       <= '0;
            img_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            image_start_q <= image_start_d;
            cur_bank_q    <= cur_bank_d;
            next_flag_q   <= next_flag_d;
            ram_en_q      <= ram_en_d;
            ram_addr_q    <= ram_addr_d;
            grant_q       <= grant_d;
            img_done_q    <= img_done_d;
        end
    end

    assign bus.ram_en         = ram_en_q;
    assign bus.ram_addr       = ram_addr_q;
    assign bus.id_fifo_read   = grant_q;
    assign bus.vec_fifo_wr_en = grant_q;
    assign bus.cur_bank       = cur_bank_q;
    assign bus.img_done       = img_done_q;

endmodule
